// File: rtl/mem_serial_loader_if.sv
// mem_serial_loader_if: word-wide memory request bus.
// master issues cs/we/addr/din, slave returns dout.
interface mem_serial_loader_if #(
  parameter int AW = 3,
  parameter int DW = 16
);
  logic          cs;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  modport master (
    output cs, we, addr, din,
    input  dout
  );

  modport slave (
    input  cs, we, addr, din,
    output dout
  );
endinterface

// File: rtl/mem_serial_loader.sv
// mem_serial_loader: bit-serial host port in front of the data memory.
// Frames become single memory accesses; idle passes the CPU through.
module mem_serial_loader #(
  parameter int AW = 3,
  parameter int DW = 16
) (
  input  logic                clkp,
  input  logic                rstp,
  input  logic                sen,
  input  logic                sval,
  input  logic                sdi,
  output logic                sdo,
  output logic                busy,
  mem_serial_loader_if.slave  cpu,
  mem_serial_loader_if.master mem
);

  localparam int HB = AW + 1;
  localparam int SW = AW + DW;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] HLAST = CW'(HB - 1);
  localparam logic [CW-1:0] DLAST = CW'(DW - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    READ,
    CAPT,
    SHOUT,
    DONE
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [SW-1:0] in_sh;
  logic [DW-1:0] out_sh;
  logic          shift_in;

  logic          ld_cs;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_din;

  assign shift_in = sval & ((state == HDR) | (state == DATA));

  // next state and bit counter; sen low aborts any frame
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    if ((state != IDLE) && !sen) begin
      nxt     = IDLE;
      cnt_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sen) nxt = HDR;
        end
        HDR: begin
          if (sval) begin
            if (cnt == HLAST) begin
              cnt_nxt = '0;
              nxt     = in_sh[AW-1] ? DATA : READ;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (sval) begin
            if (cnt == DLAST) begin
              cnt_nxt = '0;
              nxt     = WRITE;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        WRITE: nxt = DONE;
        READ:  nxt = CAPT;
        CAPT:  nxt = SHOUT;
        SHOUT: begin
          if (sval) begin
            if (cnt == DLAST) begin
              cnt_nxt = '0;
              nxt     = DONE;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        DONE: nxt = DONE;
      endcase
    end
  end

  // state and counter registers
  always_ff @(posedge clkp or posedge rstp) begin
    if (rstp) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  // serial in/out shift registers
  always_ff @(posedge clkp or posedge rstp) begin
    if (rstp) begin
      in_sh  <= '0;
      out_sh <= '0;
    end else begin
      if (shift_in) in_sh <= {in_sh[SW-2:0], sdi};
      if (state == CAPT) begin
        out_sh <= mem.dout;
      end else if ((state == SHOUT) && sval) begin
        out_sh <= {out_sh[DW-2:0], 1'b0};
      end
    end
  end

  // memory drivers move on negedge so they are flat across the high phase
  always_ff @(negedge clkp or posedge rstp) begin
    if (rstp) begin
      ld_cs   <= 1'b0;
      ld_we   <= 1'b0;
      ld_addr <= '0;
      ld_din  <= '0;
    end else begin
      ld_cs <= (state == WRITE) | (state == READ);
      ld_we <= (state == WRITE);
      if (state == WRITE) begin
        ld_addr <= in_sh[SW-1:DW];
        ld_din  <= in_sh[DW-1:0];
      end else if (state == READ) begin
        ld_addr <= in_sh[AW-1:0];
      end
    end
  end

  // port ownership mux and serial output
  always_comb begin
    busy     = sen | (state != IDLE);
    mem.cs   = busy ? ld_cs   : cpu.cs;
    mem.we   = busy ? ld_we   : cpu.we;
    mem.addr = busy ? ld_addr : cpu.addr;
    mem.din  = busy ? ld_din  : cpu.din;
    cpu.dout = mem.dout;
    sdo      = (state == SHOUT) & out_sh[DW-1];
  end

endmodule

// File: tb/tb_mem_serial_loader.sv
// tb_mem_serial_loader: random frames against a word-level memory model.
// Writes and reads are scored by a monitor watching the memory port and sdo.
module tb_mem_serial_loader;
  localparam int AW = 3;
  localparam int DW = 16;

  logic clkp = 1'b0;
  logic rstp;
  logic sen;
  logic sval;
  logic sdi;
  logic sdo;
  logic busy;

  mem_serial_loader_if #(.AW(AW), .DW(DW)) cpu_bus ();
  mem_serial_loader_if #(.AW(AW), .DW(DW)) mem_bus ();

  mem_serial_loader #(.AW(AW), .DW(DW)) dut (
    .clkp (clkp),
    .rstp (rstp),
    .sen  (sen),
    .sval (sval),
    .sdi  (sdi),
    .sdo  (sdo),
    .busy (busy),
    .cpu  (cpu_bus.slave),
    .mem  (mem_bus.master)
  );

  always #5 clkp = ~clkp;

  // 8x16 memory: writes on cs&we, read data latched on cs&~we
  logic [DW-1:0] ram [8] = '{default: '0};
  always @(posedge clkp) begin
    if (mem_bus.cs && mem_bus.we && (mem_bus.addr < 3'd4))
      ram[mem_bus.addr] <= mem_bus.din;
    if (mem_bus.cs && !mem_bus.we)
      mem_bus.dout <= ram[mem_bus.addr];
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_wr [$];
  logic [DW-1:0] exp_rd [$];
  logic [DW-1:0] ref_mem [8] = '{default: '0};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // monitor: score memory writes and serial read words
  logic          sdo_q = 1'b0;
  int            rd_phase = 0;
  int            nbits = 0;
  logic [DW-1:0] got_rd = '0;

  always @(negedge clkp) begin
    sdo_q = sdo;
    if (rd_phase != 2) begin
      checks++;
      if (sdo !== 1'b0) begin
        errors++;
        $display("FAIL sdo_idle got=%b exp=0 t=%0t", sdo, $time);
      end
    end
  end

  always @(posedge clkp) begin
    wr_t e;
    logic [DW-1:0] r;
    #1;
    if (!rstp) begin
      if (mem_bus.cs && mem_bus.we) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got=%0d:%h exp=none t=%0t",
                   mem_bus.addr, mem_bus.din, $time);
        end else begin
          e = exp_wr.pop_front();
          if (mem_bus.addr !== e.a || mem_bus.din !== e.d) begin
            errors++;
            $display("FAIL write got=%0d:%h exp=%0d:%h t=%0t",
                     mem_bus.addr, mem_bus.din, e.a, e.d, $time);
          end
        end
      end
      if (rd_phase == 2 && sval) begin
        got_rd = {got_rd[DW-2:0], sdo_q};
        nbits++;
        if (nbits == DW) begin
          rd_phase = 0;
          checks++;
          if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read got=%h exp=none t=%0t",
                     got_rd, $time);
          end else begin
            r = exp_rd.pop_front();
            if (got_rd !== r) begin
              errors++;
              $display("FAIL read got=%h exp=%h t=%0t", got_rd, r, $time);
            end
          end
        end
      end else if (rd_phase == 1) begin
        rd_phase = 2;
        nbits = 0;
      end
      if (rd_phase == 0 && mem_bus.cs && !mem_bus.we) rd_phase = 1;
    end
  end

  // write frame; abort_at >= 0 drops sen together with that bit
  task automatic write_frame(input logic [2:0] a, input logic [15:0] d,
                             input bit gap, input int abort_at);
    logic [19:0] fr;
    wr_t w;
    fr = {1'b1, a, d};
    @(negedge clkp); sen = 1'b1; sval = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (gap && i > 0) begin
        @(negedge clkp); sval = 1'b0; sdi = 1'($urandom);
      end
      @(negedge clkp); sval = 1'b1; sdi = fr[19-i];
      if (i == abort_at) begin
        sen = 1'b0;
        return;
      end
    end
    w.a = a;
    w.d = d;
    exp_wr.push_back(w);
    if (a < 3'd4) ref_mem[a] = d;
    @(negedge clkp); sval = 1'($urandom); sdi = 1'($urandom);
    @(negedge clkp); sen = 1'b0; sval = 1'b0;
  endtask

  task automatic read_frame(input logic [2:0] a, input bit gap);
    logic [3:0] fr;
    fr = {1'b0, a};
    exp_rd.push_back(ref_mem[a]);
    @(negedge clkp); sen = 1'b1; sval = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (gap && i > 0) begin
        @(negedge clkp); sval = 1'b0; sdi = 1'($urandom);
      end
      @(negedge clkp); sval = 1'b1; sdi = fr[3-i];
    end
    @(negedge clkp); sval = 1'($urandom); sdi = 1'($urandom);
    @(negedge clkp); sval = 1'($urandom); sdi = 1'($urandom);
    for (int i = 0; i < 16; i++) begin
      if (gap) begin
        @(negedge clkp); sval = 1'b0;
      end
      @(negedge clkp); sval = 1'b1; sdi = 1'($urandom);
    end
    @(negedge clkp); sen = 1'b0; sval = 1'b0;
  endtask

  // reset pulse after k bits of a write frame
  task automatic rst_mid(input logic [2:0] a, input logic [15:0] d,
                         input int k);
    logic [19:0] fr;
    fr = {1'b1, a, d};
    @(negedge clkp); sen = 1'b1; sval = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(negedge clkp); sval = 1'b1; sdi = fr[19-i];
    end
    @(negedge clkp); rstp = 1'b1; sval = 1'b0;
    #1;
    chk("rst_busy_sen", busy, 1);
    chk("rst_mem_cs", mem_bus.cs, 0);
    chk("rst_mem_we", mem_bus.we, 0);
    chk("rst_mem_addr", mem_bus.addr, 0);
    chk("rst_mem_din", mem_bus.din, 0);
    chk("rst_sdo", sdo, 0);
    sen = 1'b0;
    #1;
    chk("rst_state_idle", busy, 0);
    @(negedge clkp); rstp = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ra;
    logic [15:0] rd;
    bit          rg;
    int          ab;

    rstp = 1'b1; sen = 1'b0; sval = 1'b0; sdi = 1'b0;
    cpu_bus.cs = 1'b0; cpu_bus.we = 1'b0;
    cpu_bus.addr = '0; cpu_bus.din = '0;
    repeat (2) @(negedge clkp);
    chk("reset_busy", busy, 0);
    chk("reset_sdo", sdo, 0);
    sen = 1'b1;
    #1;
    chk("reset_busy_sen", busy, 1);
    chk("reset_mem_cs", mem_bus.cs, 0);
    chk("reset_mem_addr", mem_bus.addr, 0);
    chk("reset_mem_din", mem_bus.din, 0);
    sen = 1'b0;
    @(negedge clkp); rstp = 1'b0;

    // CPU pass-through, one write cycle
    @(negedge clkp);
    cpu_bus.cs = 1'b1; cpu_bus.we = 1'b1;
    cpu_bus.addr = 3'd0; cpu_bus.din = 16'h1234;
    #1;
    chk("pt_busy", busy, 0);
    chk("pt_cs", mem_bus.cs, 1);
    chk("pt_we", mem_bus.we, 1);
    chk("pt_addr", mem_bus.addr, 0);
    chk("pt_din", mem_bus.din, 16'h1234);
    exp_wr.push_back('{a: 3'd0, d: 16'h1234});
    ref_mem[0] = 16'h1234;
    @(negedge clkp);
    sen = 1'b1;
    #1;
    chk("pt_sen_busy", busy, 1);
    chk("pt_sen_cs", mem_bus.cs, 0);
    cpu_bus.cs = 1'b0; cpu_bus.we = 1'b0;
    @(negedge clkp); sen = 1'b0;

    write_frame(3'd2, 16'hA5C3, 1'b0, -1);
    read_frame(3'd2, 1'b0);
    rst_mid(3'd2, 16'h5555, 10);
    read_frame(3'd2, 1'b0);
    write_frame(3'd1, 16'h8001, 1'b1, -1);
    read_frame(3'd1, 1'b1);
    write_frame(3'd3, 16'hBEEF, 1'b0, 14);
    read_frame(3'd3, 1'b0);
    write_frame(3'd1, 16'hFFFF, 1'b0, 19);
    read_frame(3'd1, 1'b0);
    write_frame(3'd0, 16'hFFFF, 1'b0, -1);
    write_frame(3'd3, 16'h0F0F, 1'b0, -1);
    read_frame(3'd0, 1'b0);
    read_frame(3'd3, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = 3'($urandom_range(0, 3));
      rd = 16'($urandom);
      rg = 1'($urandom);
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 19)) : -1;
      if ($urandom_range(0, 1) == 0) write_frame(ra, rd, rg, ab);
      else read_frame(ra, rg);
    end

    repeat (5) @(negedge clkp);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("rd_idle", rd_phase, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_serial_loader.md
# mem_serial_loader

Bit-serial host port placed directly upstream of the 8x16 data memory. It collects write or read frames from an external programmer one bit per qualified cycle and turns each frame into a single memory access. It drives the memory's cs/we/addr/din and shifts read data back out serially. When idle it passes the CPU's memory request through untouched, so the host can preload or inspect memory while the CPU is held off by `busy`.

## Interface
Parameters
- AW, 3, memory address width
- DW, 16, memory data width

Ports
- clkp  in  1  system clock
- rstp  in  1  reset; asynchronous, active-high
- sen  in  1  frame enable from host; high for the whole frame
- sval  in  1  bit qualifier; sdi sampled / sdo shifted on posedge clkp when high
- sdi  in  1  serial data in, MSB first
- sdo  out  1  serial read data out, MSB first
- busy  out  1  loader owns the memory port; CPU must stall
- cpu_cs, cpu_we  in  1 each  CPU memory request
- cpu_addr  in  AW  CPU address
- cpu_din  in  DW  CPU write data
- mem_cs, mem_we  out  1 each  to memory
- mem_addr  out  AW  to memory
- mem_din  out  DW  to memory
- mem_dout  in  DW  memory read data (latched by the memory while cs & ~we)

## Operation
- Frame format, MSB first: bit 0 = RW (1 = write), then addr[2:0], then 16 data bits for writes only. Write frame = 20 bits, read header = 4 bits.
- States:
  - IDLE: sen high -> HDR.
  - HDR: counts 4 sval bits -> DATA if RW=1, else READ.
  - DATA: counts 16 sval bits -> WRITE.
  - WRITE: one cycle -> DONE.
  - READ: one cycle -> CAPT.
  - CAPT: one cycle, loads mem_dout into the 16-bit out shift register -> SHOUT.
  - SHOUT: counts 16 sval shifts -> DONE.
  - DONE: waits for sen low -> IDLE.
- Abort: sen low in any state other than IDLE returns to IDLE on the next posedge. An aborted frame never asserts mem_we. The bit counter clears.
- Port ownership:
  - busy = sen | (state != IDLE), combinational.
  - busy low: mem_* = cpu_* combinationally (pass-through).
  - busy high: mem_* come from the loader's registered drivers. The loader drives mem_cs = mem_we = 0 except in WRITE (cs=1, we=1) and READ (cs=1, we=0).
- Loader mem_cs/mem_we/mem_addr/mem_din drivers update on the negedge of clkp. They are therefore stable through the whole high phase, as the memory's gated row clock (we & cs & clk) requires.
- Addresses 4-7 are forwarded unchanged. The memory ignores writes to them. Reads return undefined data, and the bench must not check it.
- sdo = out_shift[15] in SHOUT; 0 in every other state. The register shifts left, filling with 0, on each sval in SHOUT.
- sval in WRITE, READ, CAPT or DONE is ignored. sdi is ignored outside HDR/DATA.

## Timing
- Reset values:
  - state IDLE, counters 0, shift registers 0.
  - sdo 0.
  - loader drivers mem_cs/mem_we 0, mem_addr 0, mem_din 0.
  - busy follows sen.
- Write: last data bit sampled at posedge N.
  - WRITE spans N..N+1.
  - mem_cs/mem_we high from negedge after N to negedge after N+1.
  - Memory captures on posedge N+1.
  - DONE from N+1.
- Read: last header bit sampled at posedge N.
  - READ cycle N..N+1 with cs=1, we=0.
  - CAPT loads mem_dout at posedge N+2.
  - sdo = data[15] valid from N+2.
  - Each subsequent sval posedge advances one bit. After the 16th shift -> DONE.
- Minimum write frame turnaround: 20 sval cycles + 1 WRITE + sen low for 1 cycle.
- sen falling on the same edge as the 20th bit: the frame aborts and no write occurs. sen must stay high through the WRITE cycle.
- rstp asserted mid-frame: immediate return to IDLE with drivers 0. Memory contents are not touched by the loader.

## Test plan
- Reset: rstp pulse mid-DATA -> state IDLE, sdo=0, mem_we=0 immediately. A later read of that address returns its pre-frame value.
- Write then read: write frame RW=1, addr=2, data=16'hA5C3 -> exactly one mem_we cycle with mem_addr=2. A read frame for addr=2 then gives sdo bits 1010_0101_1100_0011.
- Gapped sval: write 16'h8001 to addr 1 with sval low on every other cycle -> the same single write occurs, and the readback equals 16'h8001.
- Abort: drop sen after 10 data bits of a write to addr 3 -> mem_we never asserted, and addr 3 still reads 16'h0000 after reset.
- Pass-through: sen low, cpu_cs=1, cpu_we=1, cpu_addr=0, cpu_din=16'h1234 -> mem_* mirror cpu_* and busy=0. Raising sen makes busy=1 and drops mem_cs to 0 in the same cycle.
- Back-to-back: write addr 0 = 16'hFFFF, then addr 3 = 16'h0F0F, with 1 cycle of sen low between frames -> both reads return the written values.
